hazard_ctrl: RTL

Pipeline control block that drives the stall/flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers, and consumes their outputs.
- Detects load-use hazards, taken-branch redirects and multi-cycle data-memory waits.
- Produces EX-stage forwarding selects.
- Holds the pipeline flushed for a fixed warm-up period after reset.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

---
 rtl/hazard_ctrl_pkg.sv | 27 ++
 rtl/hazard_ctrl_fwd_unit.sv | 28 ++
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // Bypass source for one EX operand; the younger EX/MEM result wins.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] exmem_rd,
    input logic       exmem_we,
    input logic [4:0] memwb_rd,
    input logic       memwb_we
  );
    if (exmem_we && exmem_rd != 5'd0 && exmem_rd == rs) return FWD_EXMEM;
    if (memwb_we && memwb_rd != 5'd0 && memwb_rd == rs) return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// EX-stage operand bypass selection, purely combinational.
module fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] idex_rs1,
  input  logic [4:0] idex_rs2,
  input  logic [4:0] exmem_rd,
  input  logic       exmem_reg_write,
  input  logic [4:0] memwb_rd,
  input  logic       memwb_reg_write,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  logic [1:0][4:0] rs;
  logic [1:0][1:0] sel;

  assign rs = {idex_rs2, idex_rs1};

  // One selector per operand, identical logic.
  for (genvar i = 0; i < 2; i++) begin : g_op
    assign sel[i] = fwd_sel(rs[i], exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write);
  end

  assign fwd_a = sel[0];
  assign fwd_b = sel[1];

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls/flushes, forwarding, perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int RESET_FLUSH = 2,
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       idex_rs1,
  input  logic [4:0]       idex_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_mem_read,
  input  logic [4:0]       exmem_rd,
  input  logic             exmem_reg_write,
  input  logic [4:0]       memwb_rd,
  input  logic             memwb_reg_write,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  state_t        state, state_nxt;
  logic [3:0]    warm, warm_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic          tmo_release, freeze, load_use;

  fwd_unit u_fwd (
    .idex_rs1        (idex_rs1),
    .idex_rs2        (idex_rs2),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b)
  );

  // Hazard detection and next-state / stall-flush decode.
  always_comb begin
    tmo_release  = (state == ST_MEM_WAIT) && (wait_cnt == WW'(MEM_TIMEOUT))
                   && dmem_req && !dmem_ready;
    freeze       = dmem_req & ~dmem_ready & ~tmo_release;
    load_use     = idex_mem_read && (idex_rd != 5'd0) &&
                   ((id_uses_rs1 && idex_rd == id_rs1) ||
                    (id_uses_rs2 && idex_rd == id_rs2));
    state_nxt    = state;
    warm_nxt     = warm;
    wait_nxt     = wait_cnt;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    case (state)
      ST_INIT: begin
        pc_stall    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (warm == 4'(RESET_FLUSH - 1)) begin
          state_nxt = ST_RUN;
          warm_nxt  = 4'd0;
        end else begin
          warm_nxt  = warm + 4'd1;
        end
      end
      ST_RUN, ST_MEM_WAIT: begin
        if (freeze) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_stall = 1'b1;
        end else if (branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
        end else if (load_use) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_flush  = 1'b1;
        end
        if (freeze) begin
          state_nxt = ST_MEM_WAIT;
          wait_nxt  = (state == ST_RUN) ? WW'(1) : wait_cnt + WW'(1);
        end else begin
          state_nxt = ST_RUN;
          wait_nxt  = '0;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // State, warm-up and wait counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      warm     <= 4'd0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      warm     <= warm_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Saturating perf counters and sticky timeout flag; warm-up is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (state != ST_INIT && pc_stall && stall_cnt != '1)    stall_cnt <= stall_cnt + 1'b1;
      if (state != ST_INIT && id_ex_flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      if (tmo_release) mem_timeout <= 1'b1;
    end
  end

endmodule
